// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one 8-N-1 byte
// transmitter between NREQ requesters. A grant is held from the first byte
// of a message through the byte flagged last, so messages never interleave.
// A watchdog revokes the grant when the holder stops presenting bytes.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096,
  parameter int TOW     = 13
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_strobe,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [TOW-1:0]    wdog_q, wdog_d;
  logic [1:0]        holdoff_q, holdoff_d;
  logic              last_q, last_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_strobe_q, tx_strobe_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic              timeout_q, timeout_d;

  logic              arb_found;
  logic [IW-1:0]     arb_pick;
  logic [NREQ-1:0]   arb_onehot;
  logic              sel_req, sel_valid, sel_last;
  logic [7:0]        sel_data;
  logic [IW-1:0]     rr_next;
  logic              rel_grant;

  // Pointer that follows the current owner, used when the grant is released.
  assign rr_next = IW'((int'(gidx_q) + 1) % NREQ);

  // Round-robin pick: first requesting index found searching upward from rr_q.
  always_comb begin
    arb_found  = 1'b0;
    arb_pick   = '0;
    arb_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!arb_found && req[j] && (j == (int'(rr_q) + i) % NREQ)) begin
          arb_found     = 1'b1;
          arb_pick      = IW'(j);
          arb_onehot[j] = 1'b1;
        end
      end
    end
  end

  // Select the granted requester's signals through the one-hot grant mask.
  always_comb begin
    sel_req   = |(req & grant_q);
    sel_valid = |(req_valid & grant_q);
    sel_last  = |(req_last & grant_q);
    sel_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        sel_data = sel_data | req_data[8*i +: 8];
      end
    end
  end

  // Next-state logic: arbitration, byte hand-off, watchdog and release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    wdog_d      = wdog_q;
    holdoff_d   = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    tx_strobe_d = 1'b0;
    req_ack_d   = '0;
    timeout_d   = 1'b0;
    rel_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_onehot;
          gidx_d  = arb_pick;
          wdog_d  = '0;
          state_d = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (sel_valid && tx_ready && (holdoff_q == 2'd0)) begin
          tx_data_d   = sel_data;
          tx_strobe_d = 1'b1;
          req_ack_d   = grant_q;
          holdoff_d   = 2'd2;
          wdog_d      = '0;
          last_d      = sel_last;
          state_d     = SEND;
        end else if (!sel_valid && !sel_req) begin
          rel_grant = 1'b1;
        end else if (!sel_valid) begin
          if (wdog_q == TOW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            rel_grant = 1'b1;
          end else begin
            wdog_d = wdog_q + TOW'(1);
          end
        end
      end
      SEND: begin
        if (last_q) begin
          rel_grant = 1'b1;
        end else begin
          state_d = WAIT_BYTE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rel_grant) begin
      grant_d = '0;
      state_d = IDLE;
      rr_d    = rr_next;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      wdog_q      <= '0;
      holdoff_q   <= 2'd0;
      last_q      <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_strobe_q <= 1'b0;
      req_ack_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      wdog_q      <= wdog_d;
      holdoff_q   <= holdoff_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
      req_ack_q   <= req_ack_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign req_ack     = req_ack_q;
  assign tx_data     = tx_data_q;
  assign tx_strobe   = tx_strobe_q;
  assign timeout_evt = timeout_q;
  assign busy        = (state_q != IDLE);

endmodule
